// File: rtl/uart_frame_tx_if.sv
// FIFO read-side bundle between the 80-to-8 byte FIFO and the framed UART transmitter.
// The transmitter is the master: it drives the pop strobe and consumes data/empty.
interface uart_frame_tx_if;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_rd_en;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd_en
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd_en
    );
endinterface

// File: rtl/uart_frame_tx.sv
// Framed 8N1 UART transmitter: SYNC byte, BYTES_PER_FRAME payload bytes
// pulled from the FIFO, then the XOR checksum of the payload, LSB first.
module uart_frame_tx #(
    parameter int          CLKS_PER_BIT    = 868,
    parameter int          BYTES_PER_FRAME = 10,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    uart_frame_tx_if.master       fifo,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frames_sent
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [8:0]    SLOT_CSUM = 9'(BYTES_PER_FRAME + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [8:0]      r_slot;
    logic [7:0]      r_csum;
    logic [7:0]      r_shift;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic            r_tx;
    logic            r_rd_en;
    logic            r_busy;
    logic [15:0]     r_frames_sent;

    logic            w_bit_done;

    assign w_bit_done      = (r_baud == BAUD_LAST);
    assign tx              = r_tx;
    assign busy            = r_busy;
    assign frames_sent     = r_frames_sent;
    assign fifo.fifo_rd_en = r_rd_en;

    // Frame sequencer: slot selection, bit timing and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_slot        <= '0;
            r_csum        <= '0;
            r_shift       <= '0;
            r_baud        <= '0;
            r_bit         <= '0;
            r_tx          <= 1'b1;
            r_rd_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (enable && !fifo.fifo_empty) begin
                        r_state <= S_LOAD;
                        r_slot  <= '0;
                        r_csum  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (r_slot == 9'd0) begin
                        r_shift <= SYNC_BYTE;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else if (r_slot == SLOT_CSUM) begin
                        r_shift <= r_csum;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else if (!fifo.fifo_empty) begin
                        r_shift <= fifo.fifo_dout;
                        r_csum  <= r_csum ^ fifo.fifo_dout;
                        r_rd_en <= 1'b1;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else begin
                        // Payload underflow: hold the line idle until a byte arrives.
                        r_tx <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        r_baud <= '0;
                        if (r_slot == SLOT_CSUM) begin
                            r_frames_sent <= r_frames_sent + 16'd1;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_slot  <= r_slot + 9'd1;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: FIFO model, UART line decoder and
// hand-computed frame contents, spans and counters.
module tb_uart_frame_tx;

    localparam int CPB = 4;
    localparam int BPF = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        tx;
    logic        busy;
    logic [15:0] frames_sent;

    uart_frame_tx_if fif ();

    uart_frame_tx #(
        .CLKS_PER_BIT    (CPB),
        .BYTES_PER_FRAME (BPF),
        .SYNC_BYTE       (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo        (fif),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // FIFO model: pops on the strobe, presents the head byte.
    logic [7:0] fq[$];
    int         pops    = 0;
    int         bad_pop = 0;
    bit         hold    = 1'b0;

    initial begin
        fif.fifo_empty = 1'b1;
        fif.fifo_dout  = 8'h00;
    end

    always @(negedge clk) begin
        if (fif.fifo_rd_en === 1'b1) begin
            if (fq.size() == 0) bad_pop++;
            else begin
                void'(fq.pop_front());
                pops++;
            end
        end
        fif.fifo_empty = hold || (fq.size() == 0);
        fif.fifo_dout  = (fq.size() > 0) ? fq[0] : 8'h00;
    end

    // UART line decoder, samples mid-bit.
    logic [7:0] rx_q[$];
    bit         rx_on  = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh  = 8'h00;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 1;
            end
        end else begin
            if (rx_cnt >= CPB + CPB / 2 && rx_cnt < 9 * CPB &&
                ((rx_cnt - CPB / 2) % CPB) == 0)
                rx_sh = {tx, rx_sh[7:1]};
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back(rx_sh);
                rx_on = 1'b0;
            end
            rx_cnt++;
        end
    end

    logic [7:0] exp_b[12];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_exp(input logic [7:0] first, input logic [7:0] step,
                           input logic [7:0] csum);
        exp_b[0] = 8'hA5;
        for (int i = 0; i < BPF; i++)
            exp_b[i + 1] = first + step * 8'(i);
        exp_b[11] = csum;
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_rx_count"}, 32'(rx_q.size() - base), 32'd12);
        for (int i = 0; i < 12; i++)
            if (base + i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i),
                      32'(rx_q[base + i]), 32'(exp_b[i]));
    endtask

    task automatic push_seq(input logic [7:0] first, input logic [7:0] step,
                            input int n);
        for (int i = 0; i < n; i++)
            fq.push_back(first + step * 8'(i));
    endtask

    task automatic wait_pops(input string tag, input int target);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (pops >= target) break;
            @(negedge clk);
        end
        if (i == 2000) check({tag, "_pop_timeout"}, 32'(pops), 32'(target));
    endtask

    // Wait for busy to rise, then count busy-high cycles until IDLE.
    task automatic run_frame(input string tag, output int span);
        bit ok;
        ok   = 1'b0;
        span = 0;
        for (int i = 0; i < 500; i++) begin
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check({tag, "_start_timeout"}, 32'(busy), 32'd1);
            return;
        end
        for (int i = 0; i < 3000; i++) begin
            if (busy !== 1'b1) return;
            span++;
            @(negedge clk);
        end
        check({tag, "_end_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int span;
        int base_p;
        int base_r;
        int viol;
        int seen;

        // Reset with random inputs and a loaded FIFO.
        push_seq(8'h01, 8'h01, 10);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enable = 1'($urandom_range(0, 1));
            check($sformatf("reset_outs%0d", i),
                  {13'd0, tx, fif.fifo_rd_en, busy, frames_sent},
                  {13'd0, 1'b1, 1'b0, 1'b0, 16'd0});
        end
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        cyc(3);
        check("after_reset_outs",
              {13'd0, tx, fif.fifo_rd_en, busy, frames_sent},
              {13'd0, 1'b1, 1'b0, 1'b0, 16'd0});
        check("after_reset_pops", 32'(pops), 32'd0);

        // Single frame.
        base_r = rx_q.size();
        base_p = pops;
        enable = 1'b1;
        run_frame("single", span);
        check("single_span", 32'(span), 32'd492);
        set_exp(8'h01, 8'h01, 8'h0B);
        check_stream("single", base_r);
        check("single_pops", 32'(pops - base_p), 32'd10);
        check("single_frames", 32'(frames_sent), 32'd1);
        enable = 1'b0;
        cyc(5);

        // Underflow stall after the 4th payload byte.
        base_r = rx_q.size();
        base_p = pops;
        push_seq(8'h11, 8'h11, 4);
        enable = 1'b1;
        wait_pops("stall", base_p + 4);
        cyc(50);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1 || pops != base_p + 4 || busy !== 1'b1) viol++;
            @(negedge clk);
        end
        check("stall_line_idle", 32'(viol), 32'd0);
        push_seq(8'h55, 8'h11, 6);
        run_frame("stall", span);
        set_exp(8'h11, 8'h11, 8'hBB);
        check_stream("stall", base_r);
        check("stall_pops", 32'(pops - base_p), 32'd10);
        check("stall_frames", 32'(frames_sent), 32'd2);
        enable = 1'b0;
        cyc(5);

        // Enable dropped during payload byte 3 with 20 bytes queued.
        base_r = rx_q.size();
        base_p = pops;
        push_seq(8'h30, 8'h01, 20);
        enable = 1'b1;
        wait_pops("endrop", base_p + 3);
        enable = 1'b0;
        run_frame("endrop", span);
        set_exp(8'h30, 8'h01, 8'h01);
        check_stream("endrop", base_r);
        check("endrop_frames", 32'(frames_sent), 32'd3);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b0) seen++;
            @(negedge clk);
        end
        check("endrop_no_restart", 32'(seen), 32'd0);
        check("endrop_left", 32'(fq.size()), 32'd10);
        check("endrop_pops", 32'(pops - base_p), 32'd10);

        // Reset during DATA bit 5 of payload byte 2.
        base_p = pops;
        enable = 1'b1;
        wait_pops("rst", base_p + 2);
        cyc(25);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outs",
              {13'd0, tx, fif.fifo_rd_en, busy, frames_sent},
              {13'd0, 1'b1, 1'b0, 1'b0, 16'd0});
        @(negedge clk);
        check("rst_mid_hold", {30'd0, tx, busy}, {30'd0, 1'b1, 1'b0});
        push_seq(8'h44, 8'h01, 2);
        base_r = rx_q.size();
        reset  = 1'b0;
        run_frame("rst", span);
        check("rst_span", 32'(span), 32'd492);
        set_exp(8'h3C, 8'h01, 8'h01);
        check_stream("rst", base_r);
        check("rst_frames", 32'(frames_sent), 32'd1);
        enable = 1'b0;
        cyc(5);

        // Frame counter wrap.
        force dut.r_frames_sent = 16'hFFFF;
        cyc(1);
        release dut.r_frames_sent;
        cyc(1);
        check("wrap_preset", 32'(frames_sent), 32'h0000FFFF);
        base_r = rx_q.size();
        push_seq(8'h50, 8'h01, 10);
        enable = 1'b1;
        run_frame("wrap", span);
        set_exp(8'h50, 8'h01, 8'h01);
        check_stream("wrap", base_r);
        check("wrap_frames", 32'(frames_sent), 32'd0);
        enable = 1'b0;

        check("no_empty_pops", 32'(bad_pop), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Framed UART transmitter downstream of the 80-to-8 byte FIFO. It pulls payload bytes through the FIFO's read handshake and wraps each group of `BYTES_PER_FRAME` bytes as SYNC, payload, then XOR checksum. It serialises every byte as 8N1, LSB first, on a single `tx` line to the host. With the default of 10, one frame carries one 80-bit sweep/PLL record.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- `BYTES_PER_FRAME`, 10: payload bytes per frame; range 1–255.
- `SYNC_BYTE`, 8'hA5: header byte sent first in every frame.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: allows new frames to start.
- `fifo_dout` in 8: current FIFO byte; valid whenever `fifo_empty` = 0.
- `fifo_empty` in 1: FIFO has no byte.
- `fifo_rd_en` out 1: one-cycle pop strobe; registered.
- `tx` out 1: UART line; idles high; registered.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `frames_sent` out 16: count of completed frames; wraps 16'hFFFF→0.

## Operation
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frames_sent`=0, state=IDLE, slot=0, checksum=0, baud counter=0, bit index=0.
- Frame slots: 0 = `SYNC_BYTE`; 1..`BYTES_PER_FRAME` = payload from the FIFO; `BYTES_PER_FRAME`+1 = checksum.
- Checksum is the XOR of the payload bytes only. It is cleared at frame start and updated as each payload byte is loaded.
- State IDLE: `tx`=1.
  - If `enable`=1 and `fifo_empty`=0, go to LOAD with slot=0 and checksum=0.
- State LOAD selects the byte for the current slot:
  - Payload slot with `fifo_empty`=1: stay in LOAD; `tx` stays 1 (stall, no timeout).
  - Payload slot with a byte available: capture `fifo_dout` into the shift register, pulse `fifo_rd_en` for exactly 1 cycle, fold the byte into the checksum, go to START.
  - Sync or checksum slot: load the constant or the checksum, no pop, go to START.
- State START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- State DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles, then go to STOP.
- State STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then:
  - If slot = `BYTES_PER_FRAME`+1: increment `frames_sent`, go to IDLE.
  - Otherwise: increment slot, go to LOAD.
- `enable` is sampled only in IDLE. Deasserting it mid-frame lets the frame complete.
- FIFO data is never dropped or duplicated. Exactly one pop per payload byte; `BYTES_PER_FRAME` pops per frame.
- `fifo_rd_en` is never asserted while `fifo_empty`=1 or outside LOAD.
- `reset` asserted mid-byte or mid-frame:
  - Next cycle, `tx`=1 and all state returns to reset values.
  - The partial frame is abandoned; bytes already popped are lost.

## Timing
- The IDLE cycle in which the start condition is seen is followed by the first LOAD cycle.
- The start bit appears on `tx` in the cycle after LOAD, because `tx` is registered.
- Byte period with no stall: 1 LOAD cycle + 10×`CLKS_PER_BIT` cycles.
- Unstalled frame duration, from first LOAD to re-entering IDLE: (`BYTES_PER_FRAME`+2)×(10×`CLKS_PER_BIT`+1) cycles.
- `fifo_rd_en` is high during the cycle after the LOAD cycle that captured the byte. The FIFO advances `dout` on that edge; its new value is not sampled until the next LOAD.
- `frames_sent` updates on the clock edge that leaves the final STOP bit.
- `busy` rises with entry to LOAD and falls with entry to IDLE.
- Back-to-back frames: at least 1 IDLE cycle between the checksum stop bit and the next sync LOAD.

## Test plan
- Reset check: hold `reset` for 3 cycles with random inputs → `tx`=1, `fifo_rd_en`=0, `busy`=0, `frames_sent`=0 throughout and after.
- Single frame: `CLKS_PER_BIT`=4, FIFO model preloaded with 0x01..0x0A, `enable`=1.
  - Decoded stream is A5 01 02 … 0A 0B (checksum 0x0B).
  - Exactly 10 `fifo_rd_en` pulses.
  - Frame spans 492 cycles.
  - `frames_sent`=1.
- Underflow stall: same setup, but FIFO empties after the 4th payload byte for 100 cycles, then refills.
  - `tx` stays high with no pops while stalled.
  - Resumes with a correct byte sequence and checksum.
  - No duplicate or missing bytes.
- Enable drop mid-frame: deassert `enable` during payload byte 3 with 20 bytes queued.
  - Current frame completes with its checksum.
  - No new frame starts; `busy`=0 afterwards.
  - 10 bytes remain in the FIFO.
- Reset mid-byte: assert `reset` during DATA bit 5 of payload byte 2.
  - `tx`=1 the next cycle, `busy`=0.
  - After release with `enable`=1, the next frame starts with 0xA5.
- Counter wrap: force `frames_sent` to 16'hFFFF via back-to-back frames (or force), complete one frame → `frames_sent`=0.
